flame_scheduler: RTL and testbench

- Owns the bomb/flame lifecycle for both players.
- Accepts bomb-drop requests, allocates one of NSLOTS explosion slots, and counts down each fuse in video frames.
- Then steps each slot's flame animation (sprite_num 0..LAST_SPRITE) and frees the slot.
- Outputs are per-slot position, sprite index and active flags, consumed by the flame sprite renderers and game logic.

---
 rtl/flame_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_flame_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flame_scheduler.sv
// rtl/flame_scheduler.sv - bomb/flame slot scheduler; define REMOTE_DETONATE_EN to add det1/det2
module flame_scheduler #(
    parameter int NSLOTS         = 4,
    parameter int FUSE_FRAMES    = 120,
    parameter int STEP_FRAMES    = 6,
    parameter int LAST_SPRITE    = 7,
    parameter int MAX_PER_PLAYER = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_tick,
    input  logic                 req1,
    input  logic                 req2,
    input  logic [10:0]          req1_x,
    input  logic [10:0]          req1_y,
    input  logic [10:0]          req2_x,
    input  logic [10:0]          req2_y,
`ifdef REMOTE_DETONATE_EN
    input  logic                 det1,
    input  logic                 det2,
`endif
    output logic                 ack1,
    output logic                 ack2,
    output logic [NSLOTS-1:0]    slot_active,
    output logic [NSLOTS-1:0]    slot_blast,
    output logic [11*NSLOTS-1:0] slot_x,
    output logic [11*NSLOTS-1:0] slot_y,
    output logic [4*NSLOTS-1:0]  slot_sprite,
    output logic                 blast_start
);

    localparam int FW = $clog2(FUSE_FRAMES + 1);
    localparam int SW = $clog2(STEP_FRAMES + 1);
    localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FUSE, S_BLAST} slot_state_t;

    slot_state_t   state_q  [NSLOTS];
    slot_state_t   state_d  [NSLOTS];
    logic [FW-1:0] fuse_q   [NSLOTS];
    logic [FW-1:0] fuse_d   [NSLOTS];
    logic [SW-1:0] step_q   [NSLOTS];
    logic [SW-1:0] step_d   [NSLOTS];
    logic [3:0]    sprite_q [NSLOTS];
    logic [3:0]    sprite_d [NSLOTS];
    logic [10:0]   x_q      [NSLOTS];
    logic [10:0]   x_d      [NSLOTS];
    logic [10:0]   y_q      [NSLOTS];
    logic [10:0]   y_d      [NSLOTS];
    logic          owner_q  [NSLOTS];   // 0 = player 1, 1 = player 2
    logic          owner_d  [NSLOTS];

    logic rr_q, rr_d;                   // 0 = player 1 wins contention
    logic ack1_q, ack1_d;
    logic ack2_q, ack2_d;
    logic blast_start_q, blast_start_d;

    logic          det1_w, det2_w;
    logic          free_found;
    logic [IW-1:0] free_idx;
    int            cnt1, cnt2;
    logic          elig1, elig2, grant1, grant2;
    logic [10:0]   grant_x, grant_y;

`ifdef REMOTE_DETONATE_EN
    assign det1_w = det1;
    assign det2_w = det2;
`else
    assign det1_w = 1'b0;
    assign det2_w = 1'b0;
`endif

    // State register for all slots, the round-robin pointer and the pulse outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NSLOTS; i++) begin
                state_q[i]  <= S_IDLE;
                fuse_q[i]   <= '0;
                step_q[i]   <= '0;
                sprite_q[i] <= '0;
                x_q[i]      <= '0;
                y_q[i]      <= '0;
                owner_q[i]  <= 1'b0;
            end
            rr_q          <= 1'b0;
            ack1_q        <= 1'b0;
            ack2_q        <= 1'b0;
            blast_start_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOTS; i++) begin
                state_q[i]  <= state_d[i];
                fuse_q[i]   <= fuse_d[i];
                step_q[i]   <= step_d[i];
                sprite_q[i] <= sprite_d[i];
                x_q[i]      <= x_d[i];
                y_q[i]      <= y_d[i];
                owner_q[i]  <= owner_d[i];
            end
            rr_q          <= rr_d;
            ack1_q        <= ack1_d;
            ack2_q        <= ack2_d;
            blast_start_q <= blast_start_d;
        end
    end

    // Allocation arbitration plus per-slot FUSE/BLAST countdown and animation
    always_comb begin
        for (int i = 0; i < NSLOTS; i++) begin
            state_d[i]  = state_q[i];
            fuse_d[i]   = fuse_q[i];
            step_d[i]   = step_q[i];
            sprite_d[i] = sprite_q[i];
            x_d[i]      = x_q[i];
            y_d[i]      = y_q[i];
            owner_d[i]  = owner_q[i];
        end
        blast_start_d = 1'b0;
        free_found    = 1'b0;
        free_idx      = '0;
        cnt1          = 0;
        cnt2          = 0;

        // Eligibility uses pre-edge state, so a slot freed this edge is not reusable yet
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == S_IDLE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        for (int i = 0; i < NSLOTS; i++) begin
            if (state_q[i] != S_IDLE) begin
                if (owner_q[i]) cnt2 = cnt2 + 1;
                else            cnt1 = cnt1 + 1;
            end
        end

        // The ack cycle itself is ignored so a held request cannot be granted twice
        elig1   = req1 && !ack1_q && free_found && (cnt1 < MAX_PER_PLAYER);
        elig2   = req2 && !ack2_q && free_found && (cnt2 < MAX_PER_PLAYER);
        grant1  = elig1 && (!elig2 || !rr_q);
        grant2  = elig2 && (!elig1 || rr_q);
        grant_x = grant2 ? req2_x : req1_x;
        grant_y = grant2 ? req2_y : req1_y;
        ack1_d  = grant1;
        ack2_d  = grant2;
        rr_d    = grant1 ? 1'b1 : (grant2 ? 1'b0 : rr_q);

        for (int i = 0; i < NSLOTS; i++) begin
            case (state_q[i])
                S_FUSE: begin
                    if ((owner_q[i] ? det2_w : det1_w) || (frame_tick && fuse_q[i] == FW'(1))) begin
                        state_d[i]    = S_BLAST;
                        fuse_d[i]     = '0;
                        step_d[i]     = SW'(STEP_FRAMES);
                        sprite_d[i]   = '0;
                        blast_start_d = 1'b1;
                    end else if (frame_tick) begin
                        fuse_d[i] = fuse_q[i] - 1'b1;
                    end
                end
                S_BLAST: begin
                    if (frame_tick) begin
                        if (step_q[i] != SW'(1)) begin
                            step_d[i] = step_q[i] - 1'b1;
                        end else if (sprite_q[i] != 4'(LAST_SPRITE)) begin
                            sprite_d[i] = sprite_q[i] + 1'b1;
                            step_d[i]   = SW'(STEP_FRAMES);
                        end else begin
                            state_d[i]  = S_IDLE;
                            step_d[i]   = '0;
                            sprite_d[i] = '0;
                            x_d[i]      = '0;
                            y_d[i]      = '0;
                            owner_d[i]  = 1'b0;
                        end
                    end
                end
                default: begin
                    if ((grant1 || grant2) && free_idx == IW'(i)) begin
                        state_d[i] = S_FUSE;
                        fuse_d[i]  = FW'(FUSE_FRAMES);
                        x_d[i]     = grant_x;
                        y_d[i]     = grant_y;
                        owner_d[i] = grant2;
                    end
                end
            endcase
        end
    end

    assign ack1        = ack1_q;
    assign ack2        = ack2_q;
    assign blast_start = blast_start_q;

    for (genvar g = 0; g < NSLOTS; g++) begin : g_out
        assign slot_active[g]          = (state_q[g] != S_IDLE);
        assign slot_blast[g]           = (state_q[g] == S_BLAST);
        assign slot_x[11*g +: 11]      = x_q[g];
        assign slot_y[11*g +: 11]      = y_q[g];
        assign slot_sprite[4*g +: 4]   = sprite_q[g];
    end

endmodule

// File: tb/tb_flame_scheduler.sv
// tb/tb_flame_scheduler.sv - randomized scoreboard bench for flame_scheduler
module tb_flame_scheduler;

    localparam int NS    = 4;
    localparam int FUSE  = 120;
    localparam int STEP  = 6;
    localparam int LAST  = 7;
    localparam int MAXP  = 2;
    localparam int END_T = FUSE + (LAST + 1) * STEP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n, frame_tick, req1, req2;
    logic [10:0]      req1_x, req1_y, req2_x, req2_y;
`ifdef REMOTE_DETONATE_EN
    logic             det1, det2;
`endif
    logic             ack1, ack2, blast_start;
    logic [NS-1:0]    slot_active, slot_blast;
    logic [11*NS-1:0] slot_x, slot_y;
    logic [4*NS-1:0]  slot_sprite;

    flame_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .req1        (req1),
        .req2        (req2),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req2_x      (req2_x),
        .req2_y      (req2_y),
`ifdef REMOTE_DETONATE_EN
        .det1        (det1),
        .det2        (det2),
`endif
        .ack1        (ack1),
        .ack2        (ack2),
        .slot_active (slot_active),
        .slot_blast  (slot_blast),
        .slot_x      (slot_x),
        .slot_y      (slot_y),
        .slot_sprite (slot_sprite),
        .blast_start (blast_start)
    );

    typedef struct {
        logic [NS-1:0]    act;
        logic [NS-1:0]    bl;
        logic [11*NS-1:0] x;
        logic [11*NS-1:0] y;
        logic [4*NS-1:0]  spr;
        logic             a1;
        logic             a2;
        logic             bs;
    } snap_t;

    typedef struct {
        int          p;
        int          s;
        logic [10:0] x;
        logic [10:0] y;
    } grant_t;

    snap_t  exp_q[$];
    grant_t gnt_q[$];
    int     total = 0;
    int     bad   = 0;

    // Reference model: each live slot is just "frame ticks seen since grant"
    bit          m_used  [NS];
    int          m_owner [NS];
    logic [10:0] m_x     [NS];
    logic [10:0] m_y     [NS];
    int          m_t     [NS];
    int          m_rr;
    bit          m_a1, m_a2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    initial begin
        snap_t  e;
        grant_t g;
        bit     bs, d1, d2, el1, el2;
        int     fs, win;
        int     c[2];
        forever begin
            @(posedge clk);
            d1 = 1'b0;
            d2 = 1'b0;
`ifdef REMOTE_DETONATE_EN
            d1 = det1;
            d2 = det2;
`endif
            bs = 1'b0;
            if (!reset_n) begin
                for (int s = 0; s < NS; s++) begin
                    m_used[s] = 1'b0;
                    m_t[s]    = 0;
                end
                m_rr = 0;
                m_a1 = 1'b0;
                m_a2 = 1'b0;
            end else begin
                fs = -1;
                for (int s = 0; s < NS; s++)
                    if (!m_used[s] && fs < 0) fs = s;
                c[0] = 0;
                c[1] = 0;
                for (int s = 0; s < NS; s++)
                    if (m_used[s]) c[m_owner[s]]++;
                el1 = req1 && !m_a1 && fs >= 0 && c[0] < MAXP;
                el2 = req2 && !m_a2 && fs >= 0 && c[1] < MAXP;
                win = 0;
                if (el1 && el2) win = (m_rr == 0) ? 1 : 2;
                else if (el1)   win = 1;
                else if (el2)   win = 2;
                for (int s = 0; s < NS; s++) begin
                    if (m_used[s]) begin
                        if ((m_owner[s] == 0 ? d1 : d2) && m_t[s] < FUSE) begin
                            m_t[s] = FUSE;
                            bs = 1'b1;
                        end else if (frame_tick) begin
                            m_t[s]++;
                            if (m_t[s] == FUSE)  bs = 1'b1;
                            if (m_t[s] == END_T) m_used[s] = 1'b0;
                        end
                    end
                end
                if (win != 0) begin
                    m_used[fs]  = 1'b1;
                    m_owner[fs] = win - 1;
                    m_x[fs]     = (win == 1) ? req1_x : req2_x;
                    m_y[fs]     = (win == 1) ? req1_y : req2_y;
                    m_t[fs]     = 0;
                    m_rr        = (win == 1) ? 1 : 0;
                    g.p = win;
                    g.s = fs;
                    g.x = m_x[fs];
                    g.y = m_y[fs];
                    gnt_q.push_back(g);
                end
                m_a1 = (win == 1);
                m_a2 = (win == 2);
            end
            e.act = '0;
            e.bl  = '0;
            e.x   = '0;
            e.y   = '0;
            e.spr = '0;
            for (int s = 0; s < NS; s++) begin
                if (m_used[s]) begin
                    e.act[s]        = 1'b1;
                    e.x[11*s +: 11] = m_x[s];
                    e.y[11*s +: 11] = m_y[s];
                    if (m_t[s] >= FUSE) begin
                        e.bl[s]         = 1'b1;
                        e.spr[4*s +: 4] = 4'((m_t[s] - FUSE) / STEP);
                    end
                end
            end
            e.a1 = m_a1;
            e.a2 = m_a2;
            e.bs = bs;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every registered output snapshot and each grant pulse
    initial begin
        snap_t  e;
        grant_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("slot_active", 64'(slot_active), 64'(e.act));
                chk("slot_blast",  64'(slot_blast),  64'(e.bl));
                chk("slot_x",      64'(slot_x),      64'(e.x));
                chk("slot_y",      64'(slot_y),      64'(e.y));
                chk("slot_sprite", 64'(slot_sprite), 64'(e.spr));
                chk("ack1",        64'(ack1),        64'(e.a1));
                chk("ack2",        64'(ack2),        64'(e.a2));
                chk("blast_start", 64'(blast_start), 64'(e.bs));
            end
            if (ack1 || ack2) begin
                if (gnt_q.size() == 0) begin
                    chk("grant_unexpected", 64'(1), 64'(0));
                end else begin
                    g = gnt_q.pop_front();
                    chk("grant_player", 64'(ack2 ? 2 : 1), 64'(g.p));
                    chk("grant_slot_x", 64'(slot_x[11*g.s +: 11]), 64'(g.x));
                    chk("grant_slot_y", 64'(slot_y[11*g.s +: 11]), 64'(g.y));
                end
            end
        end
    end

    // Stimulus: requests held until acked, random frame ticks, one mid-run reset
    initial begin
        int tick_pct, req_pct;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        req1       = 1'b0;
        req2       = 1'b0;
        req1_x     = '0;
        req1_y     = '0;
        req2_x     = '0;
        req2_y     = '0;
`ifdef REMOTE_DETONATE_EN
        det1 = 1'b0;
        det2 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        req1    = 1'b1;
        req1_x  = 11'd64;
        req1_y  = 11'd96;
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(negedge clk);
            if (cyc < 400)       begin tick_pct = 100; req_pct = 0;  end
            else if (cyc < 3000) begin tick_pct = 60;  req_pct = 30; end
            else if (cyc < 6000) begin tick_pct = 85;  req_pct = 90; end
            else                 begin tick_pct = 40;  req_pct = 15; end
            reset_n = !(cyc == 5000 || cyc == 5001);
            if (ack1) req1 = 1'b0;
            if (ack2) req2 = 1'b0;
            frame_tick = ($urandom_range(0, 99) < tick_pct);
            if (!req1 && !ack1 && $urandom_range(0, 99) < req_pct) begin
                req1   = 1'b1;
                req1_x = 11'($urandom);
                req1_y = 11'($urandom);
            end
            if (!req2 && !ack2 && $urandom_range(0, 99) < req_pct) begin
                req2   = 1'b1;
                req2_x = 11'($urandom);
                req2_y = 11'($urandom);
            end
`ifdef REMOTE_DETONATE_EN
            det1 = ($urandom_range(0, 99) < 2);
            det2 = ($urandom_range(0, 99) < 2);
`endif
        end
        req1       = 1'b0;
        req2       = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("grants_drained", 64'(gnt_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
